// File: rtl/fft_avalon_pkg.sv
// fft_avalon_pkg: shared widths, address map and types for the FFT Avalon write slave.
// Optional feature macro used by the top: FFT_AVALON_AUTO_START_EN.
package fft_avalon_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam addr_t NUM_SAMPLES = 9'd256;
  localparam addr_t CTRL_ADDR = 9'd256;
  localparam addr_t LAST_SAMPLE = NUM_SAMPLES - 9'd1;
endpackage

// File: rtl/fft_avalon_wr_detect.sv
// fft_avalon_wr_detect: turns a level write request into a one-shot accept on its first cycle.
module fft_avalon_wr_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic i_wr_req,
  output logic o_accept
);
  logic r_armed;
  assign o_accept = i_wr_req & r_armed;
  // Disarm while the request is held, rearm on the first idle cycle.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_armed <= 1'b1;
    else r_armed <= ~i_wr_req;
endmodule

// File: rtl/fft_avalon_slave.sv
// fft_avalon_slave: Avalon-MM write slave feeding the FFT sample SRAM and the start control.
// Define FFT_AVALON_AUTO_START_EN to start the FFT automatically once all samples are written.
module fft_avalon_slave
  import fft_avalon_pkg::*;
(
  input  logic  clk,
  input  logic  n_rst,
  input  logic  slave_chipselect,
  input  logic  slave_read,
  input  logic  slave_write,
  input  addr_t slave_address,
  input  data_t slave_writedata,
  output logic  sWriteEn,
  output addr_t wAddress,
  output data_t fft_init_data,
  output logic  fft_start
);
  logic  w_wr_req, w_accept, w_sample, w_ctrl, w_auto, w_start, w_unused;
  addr_t r_count;
  assign w_unused = slave_read;
  assign w_wr_req = slave_chipselect & slave_write;
  fft_avalon_wr_detect u_wr_detect (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_wr_req (w_wr_req),
    .o_accept (w_accept)
  );
  assign w_sample = w_accept && (slave_address < NUM_SAMPLES);
  assign w_ctrl = w_accept && (slave_address == CTRL_ADDR) && slave_writedata[0];
`ifdef FFT_AVALON_AUTO_START_EN
  assign w_auto = w_sample && (r_count == LAST_SAMPLE);
`else
  assign w_auto = 1'b0;
`endif
  assign w_start = w_ctrl | w_auto;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      sWriteEn <= 1'b0;
      wAddress <= '0;
      fft_init_data <= '0;
      fft_start <= 1'b0;
      r_count <= '0;
    end else begin
      sWriteEn <= w_sample;
      fft_start <= w_start;
      if (w_sample) begin
        wAddress <= slave_address;
        fft_init_data <= slave_writedata;
      end
      r_count <= w_start ? '0 : (w_sample && r_count != NUM_SAMPLES) ? r_count + 9'd1 : r_count;
    end
endmodule

// File: tb/tb_fft_avalon_slave.sv
// tb_fft_avalon_slave: directed self-checking bench for fft_avalon_slave.
// Handles both builds of FFT_AVALON_AUTO_START_EN.
module tb_fft_avalon_slave;
  logic clk = 1'b0, n_rst = 1'b1;
  logic cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [8:0] addr = '0;
  logic [15:0] wdata = '0;
  logic s_we, f_start;
  logic [8:0] w_addr;
  logic [15:0] f_data;
  int total = 0, bad = 0;
  int n_we = 0, n_st = 0, st_wa = -1, addr_err = 0;
  always #5 clk = ~clk;
  fft_avalon_slave dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .slave_chipselect (cs),
    .slave_read       (rd),
    .slave_write      (wr),
    .slave_address    (addr),
    .slave_writedata  (wdata),
    .sWriteEn         (s_we),
    .wAddress         (w_addr),
    .fft_init_data    (f_data),
    .fft_start        (f_start)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic c, input logic w, input logic r, input logic [8:0] a, input logic [15:0] d);
    cs = c; wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (s_we) n_we++;
    if (f_start) n_st++;
    if (f_start && s_we) st_wa = int'(w_addr);
  endtask
  task automatic clr();
    n_we = 0; n_st = 0; st_wa = -1; addr_err = 0;
  endtask
  initial begin
    #1 n_rst = 1'b0;
    #2;
    check("rst_we", {31'd0, s_we}, 0);
    check("rst_addr", {23'd0, w_addr}, 0);
    check("rst_data", {16'd0, f_data}, 0);
    check("rst_start", {31'd0, f_start}, 0);
    #3 n_rst = 1'b1;
    step(1, 1, 0, 9'd0, 16'hFFFF);
    check("first_we", {31'd0, s_we}, 1);
    check("first_addr", {23'd0, w_addr}, 0);
    check("first_data", {16'd0, f_data}, 32'hFFFF);
    step(0, 0, 0, 9'd0, 16'h0);
    check("first_we_drop", {31'd0, s_we}, 0);
    clr();
    repeat (3) step(1, 1, 0, 9'd5, 16'hF0F0);
    step(0, 0, 0, 9'd0, 16'h0);
    check("held_pulses", n_we, 1);
    check("held_addr", {23'd0, w_addr}, 5);
    check("held_data", {16'd0, f_data}, 32'hF0F0);
    step(1, 1, 0, 9'd256, 16'h0001);
    check("ctrl_start", {31'd0, f_start}, 1);
    check("ctrl_no_we", {31'd0, s_we}, 0);
    step(0, 0, 0, 9'd0, 16'h0);
    check("ctrl_start_drop", {31'd0, f_start}, 0);
    clr();
    step(1, 1, 0, 9'd256, 16'h0000);
    step(0, 0, 0, 9'd0, 16'h0);
    step(1, 1, 0, 9'd300, 16'h0001);
    step(0, 0, 0, 9'd0, 16'h0);
    check("noop_we", n_we, 0);
    check("noop_start", n_st, 0);
    check("noop_addr", {23'd0, w_addr}, 5);
    check("noop_data", {16'd0, f_data}, 32'hF0F0);
    clr();
    for (int a = 0; a < 256; a++) begin
      step(1, 1, 0, 9'(a), 16'hF0F0);
      if (!(s_we === 1'b1 && w_addr === 9'(a))) addr_err++;
      repeat (2) step(1, 1, 0, 9'(a), 16'hF0F0);
      step(0, 0, 0, 9'd0, 16'h0);
    end
    check("sweep_pulses", n_we, 256);
    check("sweep_addr_errs", addr_err, 0);
`ifdef FFT_AVALON_AUTO_START_EN
    check("sweep_auto_starts", n_st, 1);
    check("sweep_auto_addr", st_wa, 255);
`else
    check("sweep_starts", n_st, 0);
`endif
    clr();
    step(0, 1, 0, 9'bx, 16'hxxxx);
    step(0, 0, 0, 9'd0, 16'h0);
    check("cs_gate_we", n_we, 0);
    check("cs_gate_addr", {23'd0, w_addr}, 255);
    check("cs_gate_data", {16'd0, f_data}, 32'hF0F0);
    step(1, 0, 1, 9'd7, 16'h1234);
    step(0, 0, 0, 9'd0, 16'h0);
    check("read_we", n_we, 0);
    check("read_addr", {23'd0, w_addr}, 255);
    step(1, 1, 1, 9'd9, 16'hABCD);
    check("rdwr_we", {31'd0, s_we}, 1);
    check("rdwr_addr", {23'd0, w_addr}, 9);
    check("rdwr_data", {16'd0, f_data}, 32'hABCD);
    step(0, 0, 0, 9'd0, 16'h0);
    clr();
    step(1, 1, 0, 9'd3, 16'h1111);
    step(1, 1, 0, 9'd3, 16'h1111);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, s_we}, 0);
    check("mid_rst_addr", {23'd0, w_addr}, 0);
    check("mid_rst_data", {16'd0, f_data}, 0);
    check("mid_rst_start", {31'd0, f_start}, 0);
    #2 n_rst = 1'b1;
    n_we = 0;
    step(1, 1, 0, 9'd3, 16'h1111);
    check("post_rst_we", {31'd0, s_we}, 1);
    check("post_rst_addr", {23'd0, w_addr}, 3);
    step(1, 1, 0, 9'd3, 16'h1111);
    step(0, 0, 0, 9'd0, 16'h0);
    check("post_rst_pulses", n_we, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
